keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad on a Pmod header: drives one column low at a time and samples the rows.
//  The input-side counterpart of the multiplexed seven-segment scan driver.

---
 rtl/keypad_if.sv | 25 ++
 rtl/keypad_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// keypad_if: keypad column drive / row sense pins plus the key event outputs.
// master = scanner side, slave = keypad model / key consumer side.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan with per-frame debounce and one code per press.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of key_valid while a key is held.
module keypad_scanner #(
  parameter int SCAN_DIV      = 50000,
  parameter int DEBOUNCE_FRMS = 4,
  parameter int REPEAT_DLY    = 100,
  parameter int REPEAT_PER    = 20
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master kp
);

  localparam int            DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB_N     = 4'(DEBOUNCE_FRMS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_e;

  state_e        st_q, st_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    fkey_q, fkey_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic          sample;
  logic          frame_end;
  logic [3:0]    lows;
  logic [2:0]    pop;
  logic [2:0]    sum;
  logic [1:0]    ridx;
  logic [1:0]    hits_new;
  logic [3:0]    fkey_new;
  logic          res_key;
  logic          same;
  logic [3:0]    cnt_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam int            RW    = $clog2(REPEAT_DLY + REPEAT_PER + 1);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] R_TOP = RW'(REPEAT_DLY + REPEAT_PER);

  logic [RW-1:0] rep_q, rep_d, rep_inc;
`endif

  // Scan timing and per-frame hit accumulation
  always_comb begin
    sample    = div_q == DIV_LAST;
    frame_end = sample && (col_idx_q == 2'd3);
    div_d     = sample ? '0 : div_q + DW'(1);
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;

    lows = ~row_s2_q;
    pop  = 3'(lows[0]) + 3'(lows[1])
         + 3'(lows[2]) + 3'(lows[3]);
    sum  = {1'b0, hits_q} + pop;

    ridx = 2'd0;
    if (pop == 3'd1) begin
      unique case (1'b1)
        lows[0]: ridx = 2'd0;
        lows[1]: ridx = 2'd1;
        lows[2]: ridx = 2'd2;
        lows[3]: ridx = 2'd3;
      endcase
    end

    hits_new = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    fkey_new = fkey_q;
    if (hits_q == 2'd0 && pop == 3'd1)
      fkey_new = {col_idx_q, ridx};

    hits_d = hits_q;
    fkey_d = fkey_q;
    if (sample) begin
      hits_d = frame_end ? 2'd0 : hits_new;
      fkey_d = fkey_new;
    end

    // Multiple hits count as no key
    res_key = hits_new == 2'd1;
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
    same    = res_key && (fkey_new == cand_q);
    cnt_inc = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
    rep_inc = rep_q + RW'(1);
`endif

    if (frame_end) begin
      unique case (st_q)
        IDLE: begin
          if (res_key) begin
            cand_d = fkey_new;
            cnt_d  = 4'd1;
            st_d   = PRESS_DB;
            if (DB_N <= 4'd1) begin
              code_d  = fkey_new;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = 4'd0;
              st_d    = HELD;
            end
          end
        end
        PRESS_DB: begin
          if (same) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_N) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = 4'd0;
              st_d    = HELD;
            end
          end else begin
            cnt_d = 4'd0;
            st_d  = IDLE;
          end
        end
        HELD: begin
          if (!same) begin
            cnt_d = 4'd1;
            st_d  = REL_DB;
            if (DB_N <= 4'd1) begin
              cnt_d  = 4'd0;
              held_d = 1'b0;
              st_d   = IDLE;
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = rep_inc;
            if (rep_inc == R_DLY) begin
              valid_d = 1'b1;
            end else if (rep_inc == R_TOP) begin
              valid_d = 1'b1;
              rep_d   = R_DLY;
            end
`endif
          end
        end
        REL_DB: begin
          if (!same) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_N) begin
              cnt_d  = 4'd0;
              held_d = 1'b0;
              st_d   = IDLE;
            end
          end else begin
            cnt_d = 4'd0;
            st_d  = HELD;
          end
        end
        default: st_d = IDLE;
      endcase
    end

`ifdef KEYPAD_REPEAT_EN
    if (st_d != HELD)
      rep_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q  <= 4'hf;
      row_s2_q  <= 4'hf;
      div_q     <= '0;
      col_idx_q <= 2'd0;
      hits_q    <= 2'd0;
      fkey_q    <= 4'd0;
      st_q      <= IDLE;
      cnt_q     <= 4'd0;
      cand_q    <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      row_s1_q  <= kp.row;
      row_s2_q  <= row_s1_q;
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      hits_q    <= hits_d;
      fkey_q    <= fkey_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  // Columns float high (all inactive) while reset is held
  assign kp.col       = rst_n ? ~(4'b0001 << col_idx_q) : 4'b1111;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model, press table and scoreboard of key events.
// Expected codes are queued at stimulus time and matched against observed pulses.
module tb_keypad_scanner;
  localparam int SD = 8;
  localparam int DB = 3;
  localparam int RD = 6;
  localparam int RP = 2;
  localparam int FR = 4 * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_if kp();

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_FRMS(DB),
    .REPEAT_DLY(RD),
    .REPEAT_PER(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kp(kp)
  );

  logic [15:0] keys = 16'h0;

  always_comb begin
    kp.row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!kp.col[c] && keys[c*4+r])
          kp.row[r] = 1'b0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         obs_n = 0;
  logic [3:0] obs_code [256];
  int         obs_cyc  [256];

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1 && obs_n < 256) begin
      obs_code[obs_n] <= kp.key_code;
      obs_cyc[obs_n]  <= cyc;
      obs_n           <= obs_n + 1;
    end
  end

  typedef struct {
    int         c;
    int         r;
    logic [3:0] code;
  } vec_t;

  vec_t       tbl [4];
  logic [3:0] exp_q [$];
  int         rd = 0;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic score();
    while (rd < obs_n) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_pulse: got code %0h at cyc %0d want none",
                 obs_code[rd], obs_cyc[rd]);
      end else begin
        chk("key_code", 32'(obs_code[rd]), 32'(exp_q.pop_front()));
      end
      rd++;
    end
  endtask

  task automatic wait_pulses(input string nm, input int bound);
    int n;
    n = 0;
    while ((obs_n - rd) < exp_q.size() && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    if ((obs_n - rd) < exp_q.size()) begin
      nvec++;
      nerr++;
      $display("FAIL %s_timeout: got %0d pulses want %0d",
               nm, obs_n - rd, exp_q.size());
      score();
      exp_q.delete();
    end else begin
      score();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
    score();
  endtask

  initial begin
    logic [3:0] e;
    int rel, lat, base, first;
    int offs [4];

    tbl[0] = '{2, 1, 4'h9};
    tbl[1] = '{0, 0, 4'h0};
    tbl[2] = '{3, 3, 4'hF};
    tbl[3] = '{1, 2, 4'h6};
    offs   = '{RD, RD + RP, RD + 2*RP, RD + 3*RP};

    #12;
    chk("rst_col", 32'(kp.col), 32'hf);
    chk("rst_valid", 32'(kp.key_valid), 0);
    chk("rst_held", 32'(kp.key_held), 0);
    chk("rst_code", 32'(kp.key_code), 0);

    // Column rotation right after reset release
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int n = 0; n < FR; n++) begin
      e = 4'b0001 << (n / SD);
      e = ~e;
      chk("scan_col", 32'(kp.col), 32'(e));
      @(negedge clk);
      #1;
    end
    idle(2 * FR);
    chk("idle_pulses", obs_n, 0);
    chk("idle_held", 32'(kp.key_held), 0);

    // Single presses from the table
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].code);
      keys[tbl[i].c*4 + tbl[i].r] = 1'b1;
      wait_pulses("press", 4 * FR + 2);
      chk("press_held", 32'(kp.key_held), 1);
      chk("press_code", 32'(kp.key_code), 32'(tbl[i].code));
      keys = 16'h0;
      idle(5 * FR);
      chk("release_held", 32'(kp.key_held), 0);
    end

    // Bouncing (0,3) then steady: a single event
    exp_q.push_back(4'h3);
    for (int i = 0; i < 13; i++) begin
      keys[3] = ~keys[3];
      repeat (5) @(negedge clk);
    end
    keys[3] = 1'b1;
    wait_pulses("bounce", 5 * FR);
    idle(2 * FR);
    chk("bounce_code", 32'(kp.key_code), 32'h3);
    keys = 16'h0;
    idle(5 * FR);

    // Hold (1,0), add (3,2): ghosting frames release (1,0)
    exp_q.push_back(4'h4);
    keys[4] = 1'b1;
    wait_pulses("hold10", 5 * FR);
    keys[14] = 1'b1;
    idle(FR + FR / 2);
    chk("multi_held_early", 32'(kp.key_held), 1);
    idle(3 * FR);
    chk("multi_held_late", 32'(kp.key_held), 0);
    keys[4] = 1'b0;
    rel = cyc;
    exp_q.push_back(4'hE);
    wait_pulses("key32", 5 * FR);
    lat = obs_cyc[rd-1] - rel;
    chk("key32_latency_ok", 32'(lat >= 2 * FR), 1);
    keys = 16'h0;
    idle(5 * FR);

    // Reset mid press-debounce
    keys[9] = 1'b1;
    idle(FR + FR / 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(kp.key_valid), 0);
    chk("midrst_held", 32'(kp.key_held), 0);
    chk("midrst_code", 32'(kp.key_code), 0);
    chk("midrst_col", 32'(kp.col), 32'hf);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    exp_q.push_back(4'h9);
    wait_pulses("postrst", 5 * FR);
    lat = obs_cyc[rd-1] - rel;
    chk("postrst_latency_ok", 32'(lat >= 2 * FR), 1);
    keys = 16'h0;
    idle(5 * FR);

    // Long hold of (3,3)
    base = obs_n;
    exp_q.push_back(4'hF);
    keys[15] = 1'b1;
    wait_pulses("longhold", 5 * FR);
    first = obs_cyc[base];
`ifdef KEYPAD_REPEAT_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(4'hF);
`endif
    idle(12 * FR + FR / 2);
    keys = 16'h0;
    idle(5 * FR);
`ifdef KEYPAD_REPEAT_EN
    chk("rep_count", obs_n - base, 5);
    for (int k = 0; k < 4; k++)
      chk("rep_offset", obs_cyc[base+k+1] - first, offs[k] * FR);
`else
    chk("rep_count", obs_n - base, 1);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
